// File: rtl/trigger_gen_pkg.sv
// Shared definitions for the multi-channel two-stage trigger generator:
// FSM state encoding, configuration select codes and control-word layout.
package trigger_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_WAIT_B = 3'd2,
        ST_PULSE  = 3'd3,
        ST_DONE   = 3'd4
    } trig_state_e;

    localparam logic [1:0] CFG_SEL_LEVEL_A = 2'b01;
    localparam logic [1:0] CFG_SEL_LEVEL_B = 2'b10;
    localparam logic [1:0] CFG_SEL_CTRL    = 2'b11;

    localparam int CTRL_CH_A_LSB     = 0;
    localparam int CTRL_CH_B_LSB     = 3;
    localparam int CTRL_CH_BITS      = 3;
    localparam int CTRL_POL_A        = 6;
    localparam int CTRL_POL_B        = 7;
    localparam int CTRL_AUTO_REARM   = 8;
    localparam int CTRL_TIMEOUT_LSB  = 16;
    localparam int CTRL_TIMEOUT_BITS = 16;

    // The timeout field counts in units of 256 cycles.
    localparam int TIMEOUT_SHIFT = 8;

endpackage

// File: rtl/trigger_chan_sum.sv
// One ADC channel: unpacks SPW signed samples from the channel word and
// registers their sign-extended sum whenever the channel is sampled.
module trigger_chan_sum #(
    parameter int ADC_DATA_WIDTH = 16,
    parameter int SPW            = 2,
    parameter int SUM_WIDTH      = ADC_DATA_WIDTH + $clog2(SPW) + 1
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic                              sample_en_i,
    input  logic [SPW*ADC_DATA_WIDTH-1:0]     data_i,
    output logic signed [SUM_WIDTH-1:0]       sum_o
);

    logic signed [SUM_WIDTH-1:0] sample_sum;
    logic signed [SUM_WIDTH-1:0] sum_q;

    always_comb begin
        sample_sum = '0;
        for (int s = 0; s < SPW; s++) begin
            sample_sum = sample_sum
                       + SUM_WIDTH'($signed(data_i[s*ADC_DATA_WIDTH +: ADC_DATA_WIDTH]));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q <= '0;
        end else if (sample_en_i) begin
            sum_q <= sample_sum;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/trigger_gen_mc.sv
// Multi-channel two-stage trigger generator: per-channel decimated sums feed
// a stage-A / stage-B level-crossing sequence that emits a stretched trigger1.
module trigger_gen_mc
    import trigger_gen_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int ADC_DATA_WIDTH = 16,
    parameter int SPW            = 2,
    parameter int WAIT_WIDTH     = 24,
    parameter int HOLDOFF        = 3125000,
    parameter int DELAY_MULT     = 20,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                                 adc_clk,
    input  logic                                 trig_reset_n,
    input  logic [N_CH*SPW*ADC_DATA_WIDTH-1:0]   adc_data,
    input  logic [N_CH-1:0]                      adc_enable,
    input  logic [N_CH-1:0]                      adc_valid,
    input  logic                                 cfg_wr,
    input  logic [1:0]                           cfg_sel,
    input  logic [31:0]                          cfg_data,
    input  logic                                 arm,
    output logic                                 trigger0,
    output logic                                 trigger1,
    output logic [2:0]                           trig_state,
    output logic [CNT_WIDTH-1:0]                 trig_count
);

    localparam int LOG2_SPW      = $clog2(SPW);
    localparam int SUM_WIDTH     = ADC_DATA_WIDTH + LOG2_SPW + 1;
    localparam int WORD_WIDTH    = SPW * ADC_DATA_WIDTH;
    localparam int ELAPSED_WIDTH = CTRL_TIMEOUT_BITS + TIMEOUT_SHIFT;
    localparam logic [WAIT_WIDTH-1:0] HOLDOFF_CNT = WAIT_WIDTH'(HOLDOFF);

    logic signed [SUM_WIDTH-1:0] chan_sum [N_CH];

    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        trigger_chan_sum #(
            .ADC_DATA_WIDTH (ADC_DATA_WIDTH),
            .SPW            (SPW),
            .SUM_WIDTH      (SUM_WIDTH)
        ) u_sum (
            .clk_i       (adc_clk),
            .rst_ni      (trig_reset_n),
            .sample_en_i (adc_enable[k] & adc_valid[k]),
            .data_i      (adc_data[k*WORD_WIDTH +: WORD_WIDTH]),
            .sum_o       (chan_sum[k])
        );
    end

    logic signed [ADC_DATA_WIDTH-1:0]   level_a_q, level_b_q;
    logic [CTRL_CH_BITS-1:0]            ch_a_q, ch_b_q;
    logic                               pol_a_q, pol_b_q, auto_rearm_q;
    logic [CTRL_TIMEOUT_BITS-1:0]       timeout_q;

    always_ff @(posedge adc_clk or negedge trig_reset_n) begin
        if (!trig_reset_n) begin
            level_a_q    <= '0;
            level_b_q    <= '0;
            ch_a_q       <= '0;
            ch_b_q       <= '0;
            pol_a_q      <= 1'b0;
            pol_b_q      <= 1'b0;
            auto_rearm_q <= 1'b0;
            timeout_q    <= '0;
        end else if (cfg_wr) begin
            case (cfg_sel)
                CFG_SEL_LEVEL_A: level_a_q <= cfg_data[ADC_DATA_WIDTH-1:0];
                CFG_SEL_LEVEL_B: level_b_q <= cfg_data[ADC_DATA_WIDTH-1:0];
                CFG_SEL_CTRL: begin
                    ch_a_q       <= cfg_data[CTRL_CH_A_LSB +: CTRL_CH_BITS];
                    ch_b_q       <= cfg_data[CTRL_CH_B_LSB +: CTRL_CH_BITS];
                    pol_a_q      <= cfg_data[CTRL_POL_A];
                    pol_b_q      <= cfg_data[CTRL_POL_B];
                    auto_rearm_q <= cfg_data[CTRL_AUTO_REARM];
                    timeout_q    <= cfg_data[CTRL_TIMEOUT_LSB +: CTRL_TIMEOUT_BITS];
                end
                default: ;
            endcase
        end
    end

    // Out-of-range channel indices never match a loop index and fall back to channel 0.
    logic signed [SUM_WIDTH-1:0] sum_a, sum_b;

    always_comb begin
        sum_a = chan_sum[0];
        sum_b = chan_sum[0];
        for (int k = 1; k < N_CH; k++) begin
            if (int'(ch_a_q) == k) sum_a = chan_sum[k];
            if (int'(ch_b_q) == k) sum_b = chan_sum[k];
        end
    end

    logic signed [SUM_WIDTH-1:0] level_a_ext, level_b_ext;
    logic                        cross_a, cross_b;

    assign level_a_ext = SUM_WIDTH'(level_a_q) <<< LOG2_SPW;
    assign level_b_ext = SUM_WIDTH'(level_b_q) <<< LOG2_SPW;
    assign cross_a     = pol_a_q ? (sum_a < level_a_ext) : (sum_a > level_a_ext);
    assign cross_b     = pol_b_q ? (sum_b < level_b_ext) : (sum_b > level_b_ext);

    trig_state_e                state_q, state_d;
    logic [WAIT_WIDTH-1:0]      cnt_q, cnt_d;
    logic [ELAPSED_WIDTH-1:0]   elapsed_q, elapsed_d;
    logic [CNT_WIDTH-1:0]       count_q, count_d;

    logic [WAIT_WIDTH:0]        cnt_sum;
    logic [WAIT_WIDTH-1:0]      cnt_sat;
    logic [ELAPSED_WIDTH-1:0]   elapsed_inc, timeout_limit;
    logic                       timed_out;

    assign cnt_sum       = {1'b0, cnt_q} + (WAIT_WIDTH+1)'(DELAY_MULT);
    assign cnt_sat       = cnt_sum[WAIT_WIDTH] ? '1 : cnt_sum[WAIT_WIDTH-1:0];
    assign elapsed_inc   = elapsed_q + ELAPSED_WIDTH'(1);
    assign timeout_limit = {timeout_q, {TIMEOUT_SHIFT{1'b0}}};
    assign timed_out     = (timeout_q != '0) && (elapsed_inc >= timeout_limit);

    // The pulse leaves on the cycle its last count is consumed, so trigger1
    // is high for exactly the accumulated delay.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        elapsed_d = '0;
        count_d   = count_q;
        case (state_q)
            ST_IDLE: begin
                if (cnt_q == '0) state_d = ST_ARMED;
                else             cnt_d   = cnt_q - WAIT_WIDTH'(1);
            end
            ST_ARMED: begin
                cnt_d = '0;
                if (cross_a) state_d = ST_WAIT_B;
            end
            ST_WAIT_B: begin
                cnt_d     = cnt_sat;
                elapsed_d = elapsed_inc;
                if (cross_b)        state_d = ST_PULSE;
                else if (timed_out) state_d = ST_DONE;
            end
            ST_PULSE: begin
                if (cnt_q != '0) cnt_d = cnt_q - WAIT_WIDTH'(1);
                if (cnt_q <= WAIT_WIDTH'(1)) begin
                    state_d = ST_DONE;
                    if (count_q != '1) count_d = count_q + CNT_WIDTH'(1);
                end
            end
            ST_DONE: begin
                if (arm || auto_rearm_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = HOLDOFF_CNT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = HOLDOFF_CNT;
            end
        endcase
    end

    always_ff @(posedge adc_clk or negedge trig_reset_n) begin
        if (!trig_reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= HOLDOFF_CNT;
            elapsed_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            elapsed_q <= elapsed_d;
            count_q   <= count_d;
        end
    end

    assign trigger0   = (state_q == ST_ARMED);
    assign trigger1   = (state_q == ST_PULSE);
    assign trig_state = state_q;
    assign trig_count = count_q;

endmodule

// File: tb/tb_trigger_gen_mc.sv
// Directed bench for trigger_gen_mc with a sequence-level reference model
// checked every cycle, plus literal expectations at the key milestones.
module tb_trigger_gen_mc;

    localparam int N_CH       = 4;
    localparam int ADW        = 16;
    localparam int SPW        = 2;
    localparam int WAIT_WIDTH = 24;
    localparam int HOLDOFF    = 16;
    localparam int DELAY_MULT = 20;
    localparam int CNT_WIDTH  = 16;
    localparam int MAX_WAIT   = (1 << WAIT_WIDTH) - 1;
    localparam int MAX_CNT    = (1 << CNT_WIDTH) - 1;

    localparam int PH_IDLE  = 0;
    localparam int PH_ARMED = 1;
    localparam int PH_WAITB = 2;
    localparam int PH_PULSE = 3;
    localparam int PH_DONE  = 4;

    logic                          adc_clk = 1'b0;
    logic                          trig_reset_n;
    logic [N_CH*SPW*ADW-1:0]       adc_data;
    logic [N_CH-1:0]               adc_enable;
    logic [N_CH-1:0]               adc_valid;
    logic                          cfg_wr;
    logic [1:0]                    cfg_sel;
    logic [31:0]                   cfg_data;
    logic                          arm;
    logic                          trigger0;
    logic                          trigger1;
    logic [2:0]                    trig_state;
    logic [CNT_WIDTH-1:0]          trig_count;

    trigger_gen_mc #(
        .N_CH           (N_CH),
        .ADC_DATA_WIDTH (ADW),
        .SPW            (SPW),
        .WAIT_WIDTH     (WAIT_WIDTH),
        .HOLDOFF        (HOLDOFF),
        .DELAY_MULT     (DELAY_MULT),
        .CNT_WIDTH      (CNT_WIDTH)
    ) dut (
        .adc_clk      (adc_clk),
        .trig_reset_n (trig_reset_n),
        .adc_data     (adc_data),
        .adc_enable   (adc_enable),
        .adc_valid    (adc_valid),
        .cfg_wr       (cfg_wr),
        .cfg_sel      (cfg_sel),
        .cfg_data     (cfg_data),
        .arm          (arm),
        .trigger0     (trigger0),
        .trigger1     (trigger1),
        .trig_state   (trig_state),
        .trig_count   (trig_count)
    );

    always #5 adc_clk = ~adc_clk;

    int errors = 0;
    int checks = 0;
    bit cmpEnable = 1'b0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: tracks the sequence phase and how many cycles each
    // phase still has to run, derived from the trigger rules directly.
    int mPhase, mIdleLeft, mWaited, mPulseLeft, mCount;
    int mSum [N_CH];
    int mLvlA, mLvlB, mChA, mChB, mPolA, mPolB, mAuto, mTimeout;
    bit hitA, hitB;

    function automatic int sampleOf(input int ch, input int s);
        logic signed [ADW-1:0] v;
        v = adc_data[(ch*SPW + s)*ADW +: ADW];
        return int'(v);
    endfunction

    function automatic int pick(input int ch);
        return (ch < N_CH) ? ch : 0;
    endfunction

    function automatic bit crosses(input int sum, input int level, input int pol);
        int thr;
        thr = level * SPW;
        return pol != 0 ? (sum < thr) : (sum > thr);
    endfunction

    task modelReset();
        mPhase = PH_IDLE; mIdleLeft = HOLDOFF + 1; mWaited = 0; mPulseLeft = 0; mCount = 0;
        for (int k = 0; k < N_CH; k++) mSum[k] = 0;
        mLvlA = 0; mLvlB = 0; mChA = 0; mChB = 0;
        mPolA = 0; mPolB = 0; mAuto = 0; mTimeout = 0;
    endtask

    always @(posedge adc_clk or negedge trig_reset_n) begin
        if (!trig_reset_n) begin
            modelReset();
        end else begin
            hitA = crosses(mSum[pick(mChA)], mLvlA, mPolA);
            hitB = crosses(mSum[pick(mChB)], mLvlB, mPolB);
            case (mPhase)
                PH_IDLE: begin
                    mIdleLeft--;
                    if (mIdleLeft == 0) mPhase = PH_ARMED;
                end
                PH_ARMED: if (hitA) begin mPhase = PH_WAITB; mWaited = 0; end
                PH_WAITB: begin
                    mWaited++;
                    if (hitB) begin
                        mPhase = PH_PULSE;
                        mPulseLeft = (mWaited * DELAY_MULT > MAX_WAIT) ? MAX_WAIT : mWaited * DELAY_MULT;
                    end else if (mTimeout != 0 && mWaited >= mTimeout * 256) begin
                        mPhase = PH_DONE;
                    end
                end
                PH_PULSE: begin
                    mPulseLeft--;
                    if (mPulseLeft <= 0) begin
                        mPhase = PH_DONE;
                        if (mCount < MAX_CNT) mCount++;
                    end
                end
                default: if (arm || mAuto != 0) begin mPhase = PH_IDLE; mIdleLeft = HOLDOFF + 1; end
            endcase
            for (int k = 0; k < N_CH; k++) begin
                if (adc_enable[k] && adc_valid[k]) begin
                    mSum[k] = 0;
                    for (int s = 0; s < SPW; s++) mSum[k] += sampleOf(k, s);
                end
            end
            if (cfg_wr) begin
                case (cfg_sel)
                    2'b01: mLvlA = int'($signed(cfg_data[ADW-1:0]));
                    2'b10: mLvlB = int'($signed(cfg_data[ADW-1:0]));
                    2'b11: begin
                        mChA = int'(cfg_data[2:0]);  mChB = int'(cfg_data[5:3]);
                        mPolA = int'(cfg_data[6]);   mPolB = int'(cfg_data[7]);
                        mAuto = int'(cfg_data[8]);   mTimeout = int'(cfg_data[31:16]);
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge adc_clk) begin
        if (cmpEnable) begin
            checkOutput("model_state", trig_state, mPhase);
            checkOutput("model_trigger0", trigger0, mPhase == PH_ARMED);
            checkOutput("model_trigger1", trigger1, mPhase == PH_PULSE);
            checkOutput("model_count", trig_count, mCount);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge adc_clk);
        #2;
    endtask

    task automatic applyStimulus(input int ch, input int s0, input int s1);
        logic [ADW-1:0] a, b;
        a = ADW'(s0);
        b = ADW'(s1);
        adc_data[(ch*SPW)*ADW +: ADW]     = a;
        adc_data[(ch*SPW + 1)*ADW +: ADW] = b;
    endtask

    task automatic cfgWrite(input logic [1:0] sel, input logic [31:0] data);
        cfg_wr = 1'b1; cfg_sel = sel; cfg_data = data;
        tick(1);
        cfg_wr = 1'b0;
    endtask

    task automatic waitState(input int target, input int budget, input string name);
        int cycles;
        cycles = 0;
        while (int'(trig_state) != target && cycles < budget) begin
            tick(1);
            cycles++;
        end
        checkOutput(name, trig_state, target);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int idleSeen, pulses, waited, cycles;
        trig_reset_n = 1'b0;
        adc_data = '0; adc_enable = '1; adc_valid = '1;
        cfg_wr = 1'b0; cfg_sel = 2'b00; cfg_data = '0; arm = 1'b0;
        repeat (3) @(posedge adc_clk);
        cmpEnable = 1'b1;
        #2 trig_reset_n = 1'b1;
        #1;
        checkOutput("reset_state", trig_state, PH_IDLE);
        checkOutput("reset_trigger0", trigger0, 0);
        checkOutput("reset_trigger1", trigger1, 0);
        checkOutput("reset_count", trig_count, 0);
        #1;

        idleSeen = 1;
        for (int i = 0; i < 16; i++) begin
            tick(1);
            if (trig_state == 3'd0) idleSeen++;
        end
        checkOutput("holdoff_idle_cycles", idleSeen, 17);
        tick(1);
        checkOutput("armed_trigger0", trigger0, 1);

        cfgWrite(2'b01, 32'd100);
        cfgWrite(2'b10, 32'hFFFF_FFCE);
        cfgWrite(2'b11, 32'h0000_0091);
        applyStimulus(1, 60, 60);
        tick(3);
        checkOutput("below_level_stays_armed", trig_state, PH_ARMED);
        applyStimulus(1, 120, 90);
        tick(1);
        checkOutput("trigger0_one_cycle_after", trigger0, 1);
        tick(1);
        checkOutput("trigger0_falls", trigger0, 0);
        checkOutput("wait_b_entered", trig_state, PH_WAITB);

        tick(1);
        applyStimulus(1, 60, 60);
        applyStimulus(2, -60, -60);
        tick(2);
        checkOutput("pulse_entered", trig_state, PH_PULSE);
        applyStimulus(2, 0, 0);
        pulses = 0;
        while (trigger1 === 1'b1 && pulses < 200) begin
            pulses++;
            tick(1);
        end
        checkOutput("pulse_width", pulses, 60);
        checkOutput("done_after_pulse", trig_state, PH_DONE);
        checkOutput("count_after_pulse", trig_count, 1);

        tick(5);
        checkOutput("done_holds_without_arm", trig_state, PH_DONE);
        arm = 1'b1; tick(1); arm = 1'b0;
        checkOutput("arm_to_idle", trig_state, PH_IDLE);
        arm = 1'b1; tick(1); arm = 1'b0;
        checkOutput("arm_in_idle_ignored", trig_state, PH_IDLE);

        cfgWrite(2'b11, 32'h0001_0091);
        waitState(PH_ARMED, 40, "rearmed_for_timeout");
        applyStimulus(1, 120, 90);
        waitState(PH_WAITB, 5, "timeout_wait_b_entered");
        waited = 0;
        while (trig_state == 3'd2 && waited < 400) begin
            waited++;
            tick(1);
        end
        checkOutput("timeout_wait_cycles", waited, 256);
        checkOutput("timeout_done", trig_state, PH_DONE);
        checkOutput("timeout_count_unchanged", trig_count, 1);

        applyStimulus(1, 60, 60);
        cfgWrite(2'b11, 32'h0000_0091);
        arm = 1'b1; tick(1); arm = 1'b0;
        waitState(PH_ARMED, 40, "rearmed_for_valid_test");
        adc_valid[1] = 1'b0;
        applyStimulus(1, 120, 90);
        tick(5);
        checkOutput("invalid_data_ignored", trig_state, PH_ARMED);
        adc_valid[1] = 1'b1;
        tick(2);
        checkOutput("valid_data_crosses", trig_state, PH_WAITB);
        applyStimulus(2, -60, -60);
        waitState(PH_PULSE, 10, "pulse_before_reset");
        tick(10);
        checkOutput("mid_pulse_trigger1", trigger1, 1);
        trig_reset_n = 1'b0;
        #1;
        checkOutput("reset_drops_trigger1", trigger1, 0);
        checkOutput("reset_forces_idle", trig_state, PH_IDLE);
        checkOutput("reset_clears_count", trig_count, 0);
        tick(2);
        trig_reset_n = 1'b1;

        cfgWrite(2'b01, 32'd100);
        cfgWrite(2'b10, 32'hFFFF_FFCE);
        cfgWrite(2'b11, 32'h0000_0191);
        cycles = 0;
        while (trig_count != 16'd1 && cycles < 300) begin
            tick(1);
            cycles++;
        end
        checkOutput("auto_first_sequence", trig_count, 1);
        cycles = 0;
        while (trig_count != 16'd2 && cycles < 300) begin
            tick(1);
            cycles++;
        end
        checkOutput("auto_two_sequences", trig_count, 2);
        checkOutput("auto_sequence_period", cycles, 40);
        cfgWrite(2'b11, 32'h0000_0091);
        waitState(PH_DONE, 200, "third_sequence_done");
        tick(10);
        checkOutput("no_auto_stays_done", trig_state, PH_DONE);
        checkOutput("count_after_three", trig_count, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
